// File: rtl/fetch.sv
// fetch: instruction fetch register.
// Captures one program-memory byte per fetch phase and presents it as an
// opcode nibble and an operand nibble. The value is held through the execute
// phase.
//
// Ports
//   clk          in   1  system clock, rising-edge active
//   reset        in   1  asynchronous active-low reset (0 = clear)
//   programByte  in   8  byte from program memory: [7:4] opcode, [3:0] operand
//   phase        in   1  0 = fetch (load), 1 = execute (hold)
//   instruction  out  4  registered opcode nibble
//   operand      out  4  registered operand nibble
module fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] programByte,
  input  logic       phase,
  output logic [3:0] instruction,
  output logic [3:0] operand
);

  logic [7:0] fetch_reg;

  // A single 8-bit register keeps both nibbles in lockstep. programByte is
  // only sampled when phase is 0, so X/Z on it during execute never reaches
  // the register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_reg <= '0;
    end else if (!phase) begin
      fetch_reg <= programByte;
    end
  end

  assign instruction = fetch_reg[7:4];
  assign operand     = fetch_reg[3:0];

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: self-checking bench for the fetch register.
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge, or mid-cycle for the asynchronous-reset checks.
module tb_fetch;

  logic       clk;
  logic       reset;
  logic [7:0] programByte;
  logic       phase;
  logic [3:0] instruction;
  logic [3:0] operand;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: the byte most recently fetched since the last reset.
  logic [7:0] exp_byte;

  fetch dut (
    .clk         (clk),
    .reset       (reset),
    .programByte (programByte),
    .phase       (phase),
    .instruction (instruction),
    .operand     (operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge, then advance the model by
  // the fetch rule at the following rising edge.
  task automatic step(input logic [7:0] pb, input logic ph);
    @(negedge clk);
    programByte = pb;
    phase       = ph;
    @(posedge clk);
    if (reset == 1'b0) exp_byte = 8'h00;
    else if (ph == 1'b0) exp_byte = pb;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    programByte = 8'hFF;
    phase = 1'b0;
    #1;
    exp_byte = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(8'hFF, 1'b0);
      total++;
      if (instruction !== 4'h0 || operand !== 4'h0)
        $display("FAIL reset_hold cycle %0d: got %h/%h want 0/0", i, instruction, operand);
      else passed++;
    end
    // Release, load something, then clear with no clock edge.
    @(negedge clk);
    reset = 1'b1;
    step(8'h77, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    exp_byte = 8'h00;
    total++;
    if (instruction !== 4'h0 || operand !== 4'h0)
      $display("FAIL reset_async: got %h/%h want 0/0", instruction, operand);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_load();
    step(8'h0F, 1'b0);
    total++;
    if (instruction !== 4'h0 || operand !== 4'hF)
      $display("FAIL basic_load: got %h/%h want 0/f", instruction, operand);
    else passed++;
  endtask

  task automatic test_hold();
    logic [7:0] pat [4];
    pat = '{8'hF0, 8'h3C, 8'hF0, 8'h3C};
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b1);
      total++;
      if (instruction !== 4'h0 || operand !== 4'hF)
        $display("FAIL hold_exec %0d: got %h/%h want 0/f", i, instruction, operand);
      else passed++;
    end
    // X on programByte during execute must not reach the outputs.
    step(8'hxx, 1'b1);
    total++;
    if (instruction !== 4'h0 || operand !== 4'hF)
      $display("FAIL hold_x: got %h/%h want 0/f", instruction, operand);
    else passed++;
  endtask

  task automatic test_reload();
    step(8'h3C, 1'b0);
    total++;
    if (instruction !== 4'h3 || operand !== 4'hC)
      $display("FAIL reload_1: got %h/%h want 3/c", instruction, operand);
    else passed++;
    step(8'hA5, 1'b0);
    total++;
    if (instruction !== 4'hA || operand !== 4'h5)
      $display("FAIL reload_2: got %h/%h want a/5", instruction, operand);
    else passed++;
  endtask

  task automatic test_registered();
    @(negedge clk);
    phase = 1'b0;
    programByte = 8'h12;
    #2;
    total++;
    if (instruction !== 4'hA || operand !== 4'h5)
      $display("FAIL reg_between_1: got %h/%h want a/5", instruction, operand);
    else passed++;
    programByte = 8'h34;
    #1;
    total++;
    if (instruction !== 4'hA || operand !== 4'h5)
      $display("FAIL reg_between_2: got %h/%h want a/5", instruction, operand);
    else passed++;
    @(posedge clk);
    exp_byte = 8'h34;
    #1;
    total++;
    if (instruction !== 4'h3 || operand !== 4'h4)
      $display("FAIL reg_after_edge: got %h/%h want 3/4", instruction, operand);
    else passed++;
  endtask

  task automatic test_mid_reset();
    step(8'h3C, 1'b0);
    step(8'hEE, 1'b1);
    total++;
    if (instruction !== 4'h3 || operand !== 4'hC)
      $display("FAIL midrst_pre: got %h/%h want 3/c", instruction, operand);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    exp_byte = 8'h00;
    total++;
    if (instruction !== 4'h0 || operand !== 4'h0)
      $display("FAIL midrst_clear: got %h/%h want 0/0", instruction, operand);
    else passed++;
    #1;
    reset = 1'b1;
    // Execute-phase edge after release: still cleared.
    step(8'hC3, 1'b1);
    total++;
    if (instruction !== 4'h0 || operand !== 4'h0)
      $display("FAIL midrst_stay0: got %h/%h want 0/0", instruction, operand);
    else passed++;
    step(8'h5A, 1'b0);
    total++;
    if (instruction !== 4'h5 || operand !== 4'hA)
      $display("FAIL midrst_load: got %h/%h want 5/a", instruction, operand);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] pb;
    logic       ph;
    for (int i = 0; i < 300; i++) begin
      pb = 8'($urandom);
      ph = 1'($urandom);
      @(negedge clk);
      programByte = pb;
      phase = ph;
      // Occasional asynchronous reset pulse inside the low half-cycle.
      if ($urandom_range(0, 19) == 0) begin
        #1;
        reset = 1'b0;
        #1;
        exp_byte = 8'h00;
        total++;
        if (instruction !== 4'h0 || operand !== 4'h0)
          $display("FAIL rand_rst %0d: got %h/%h want 0/0", i, instruction, operand);
        else passed++;
        reset = 1'b1;
      end
      @(posedge clk);
      if (ph == 1'b0) exp_byte = pb;
      #1;
      total++;
      if (instruction !== exp_byte[7:4] || operand !== exp_byte[3:0])
        $display("FAIL rand %0d: got %h/%h want %h/%h (pb=%h ph=%0d)",
                 i, instruction, operand, exp_byte[7:4], exp_byte[3:0], pb, ph);
      else passed++;
    end
  endtask

  initial begin
    exp_byte = 8'h00;
    test_reset();
    test_basic_load();
    test_hold();
    test_reload();
    test_registered();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog: the sequence above is bounded, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout, %0d/%0d done", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset, as the codebase names them.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = normal operation.
REQ-004 programByte  input  8  instruction byte from program memory; [7:4] = opcode nibble, [3:0] = operand nibble.
REQ-005 phase  input  1  CPU phase; 0 = fetch phase (load enabled), 1 = execute phase (hold).
REQ-006 instruction  output  4  registered opcode nibble.
REQ-007 operand  output  4  registered operand nibble.
REQ-008 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-009 The block SHALL hold one 8-bit fetch register, split into instruction = reg[7:4] and operand = reg[3:0].
REQ-010 On a rising clk edge with reset=1 and phase=0, the register SHALL load programByte: instruction <= programByte[7:4], operand <= programByte[3:0].
REQ-011 On a rising clk edge with reset=1 and phase=1, the register SHALL hold its value, whatever programByte is.
REQ-012 Load latency SHALL be exactly one clk edge: new outputs are visible after the first rising edge that samples phase=0.
REQ-013 instruction and operand SHALL be driven only from the register, with no combinational path from programByte or phase to either output.
REQ-014 Changes on programByte or phase between rising edges SHALL NOT affect the outputs.
REQ-015 Both nibbles SHALL always update together; a partial-nibble update SHALL NOT occur.
REQ-016 Bit positions SHALL pass through unmodified; no decode, inversion or reordering is allowed.
REQ-017 Consecutive phase=0 edges SHALL each reload the register; the last sampled byte wins.
REQ-018 phase and programByte are synchronous to clk, and the block SHALL NOT add synchronizers for them.
REQ-019 X/Z on programByte during phase=1 SHALL NOT propagate to the outputs.

Reset
REQ-020 While reset=0, instruction SHALL be 4'h0 and operand SHALL be 4'h0, immediately and without a clock edge.
REQ-021 reset=0 SHALL take priority over phase and programByte at every clock edge.
REQ-022 When reset asserts mid-operation, including while phase=1 holds a value, the outputs SHALL clear at once.
REQ-023 After reset deasserts, the outputs SHALL stay 0 until the first rising edge with reset=1 and phase=0.
REQ-024 Reset deassertion coincident with a rising clk edge SHALL NOT load on that edge; the first load occurs on the following edge.

Verification
REQ-025 Reset check: reset=0, programByte=8'hFF, phase=0, clk toggling -> instruction=4'h0 and operand=4'h0 throughout; also check clear with no clk edge.
REQ-026 Basic load: reset=1, phase=0, programByte=8'h0F, one rising edge -> instruction=4'h0, operand=4'hF.
REQ-027 Hold in execute: after REQ-026 set phase=1, drive programByte=8'hF0 then 8'h3C over several edges -> outputs stay 4'h0 / 4'hF.
REQ-028 Reload: phase=0 with programByte=8'h3C, one rising edge -> instruction=4'h3, operand=4'hC; 8'hA5 on the next edge -> 4'hA / 4'h5.
REQ-029 Registered output: with phase=0, change programByte between edges (8'h12 -> 8'h34 before the edge) -> outputs do not change until the edge, then show 4'h3 / 4'h4.
REQ-030 Mid-operation reset: with outputs at 4'h3 / 4'hC and phase=1, pulse reset=0 between edges -> outputs become 0/0 at once; after release, the first phase=0 edge with 8'h5A gives 4'h5 / 4'hA.
